// File: rtl/lstm_fx_pkg.sv
// Fixed-point helpers shared by the LSTM cell update pipeline.
// Q16.16 words: saturating add, rounded multiply, hard sigmoid/tanh.
package lstm_fx_pkg;

  localparam int FX_W    = 32;
  localparam int FX_FRAC = 16;

  typedef logic signed [FX_W-1:0] fx_t;

  localparam fx_t ONE     = fx_t'(1 << FX_FRAC);
  localparam fx_t HALF    = fx_t'(1 << (FX_FRAC - 1));
  localparam fx_t NEG_ONE = -ONE;
  localparam fx_t FX_MAX  = {1'b0, {(FX_W-1){1'b1}}};
  localparam fx_t FX_MIN  = {1'b1, {(FX_W-1){1'b0}}};

  function automatic fx_t clamp(input fx_t x, input fx_t lo,
                                input fx_t hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic fx_t sat_add(input fx_t a, input fx_t b);
    logic signed [FX_W:0] s;
    s = {a[FX_W-1], a} + {b[FX_W-1], b};
    if (s[FX_W] != s[FX_W-1]) return s[FX_W] ? FX_MIN : FX_MAX;
    return s[FX_W-1:0];
  endfunction

  function automatic fx_t fx_mul_rnd(input fx_t a, input fx_t b);
    logic signed [2*FX_W-1:0] p;
    logic signed [2*FX_W:0]   r;
    logic [FX_W+1:0]          hi;
    p  = (2*FX_W)'(a) * (2*FX_W)'(b);
    r  = {p[2*FX_W-1], p} + {{(FX_W+1){1'b0}}, HALF};
    r  = r >>> FX_FRAC;
    hi = r[2*FX_W:FX_W-1];
    if (!((&hi) || !(|hi))) return r[2*FX_W] ? FX_MIN : FX_MAX;
    return r[FX_W-1:0];
  endfunction

  function automatic fx_t hsig(input fx_t x);
    logic signed [FX_W:0] t;
    t = {x[FX_W-1], x >>> 2} + {1'b0, HALF};
    if (t[FX_W]) return '0;
    if (t > $signed({1'b0, ONE})) return ONE;
    return t[FX_W-1:0];
  endfunction

  function automatic fx_t htanh(input fx_t x);
    return clamp(x, NEG_ONE, ONE);
  endfunction

endpackage

// File: rtl/lstm_lane_datapath.sv
// One lane of the LSTM cell update: S1..S4 arithmetic, no control.
// LSTM_CELL_CLIP_EN adds a symmetric clip on the S3 cell sum.
module lstm_lane_datapath
  import lstm_fx_pkg::*;
#(
  parameter fx_t CLIP = fx_t'(4 << FX_FRAC)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  fx_t  f_i,
  input  fx_t  g_i,
  input  fx_t  i_i,
  input  fx_t  o_i,
  input  fx_t  cp_i,
  output fx_t  c_o,
  output fx_t  h_o
);

  if (CLIP <= 0) begin : g_bad_clip
    $error("CLIP must be positive");
  end

  fx_t sf_q, si_q, so1_q, tg_q, cp_q;
  fx_t pf_q, pi_q, so2_q;
  fx_t c3_q, so3_q;
  fx_t c4_q, h4_q;
  fx_t sum_d, c3_d;

  // S3 cell sum: DATA_W saturation, then the optional clip
  always_comb begin
    sum_d = sat_add(pf_q, pi_q);
`ifdef LSTM_CELL_CLIP_EN
    c3_d = clamp(sum_d, -CLIP, CLIP);
`else
    c3_d = sum_d;
`endif
  end

  // Four stage registers, all frozen together by the stall
  always_ff @(posedge clk) begin
    if (rst) begin
      sf_q  <= '0;
      si_q  <= '0;
      so1_q <= '0;
      tg_q  <= '0;
      cp_q  <= '0;
      pf_q  <= '0;
      pi_q  <= '0;
      so2_q <= '0;
      c3_q  <= '0;
      so3_q <= '0;
      c4_q  <= '0;
      h4_q  <= '0;
    end else if (en_i) begin
      sf_q  <= hsig(f_i);
      si_q  <= hsig(i_i);
      so1_q <= hsig(o_i);
      tg_q  <= htanh(g_i);
      cp_q  <= cp_i;
      pf_q  <= fx_mul_rnd(sf_q, cp_q);
      pi_q  <= fx_mul_rnd(si_q, tg_q);
      so2_q <= so1_q;
      c3_q  <= c3_d;
      so3_q <= so2_q;
      c4_q  <= c3_q;
      h4_q  <= fx_mul_rnd(so3_q, htanh(c3_q));
    end
  end

  assign c_o = c4_q;
  assign h_o = h4_q;

endmodule

// File: rtl/lstm_cell_update_pipe.sv
// Streaming LSTM c/h update, LANES elements per beat, 4-stage pipe.
// Optional macro LSTM_CELL_CLIP_EN clamps c_next to +/-CELL_CLIP.
module lstm_cell_update_pipe
  import lstm_fx_pkg::*;
#(
  parameter int HIDDEN    = 100,
  parameter int LANES     = 4,
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 16,
  parameter int CELL_CLIP = 4 << FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LANES*DATA_W-1:0] in_f,
  input  logic [LANES*DATA_W-1:0] in_g,
  input  logic [LANES*DATA_W-1:0] in_i,
  input  logic [LANES*DATA_W-1:0] in_o,
  input  logic [LANES*DATA_W-1:0] in_c_prev,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [LANES*DATA_W-1:0] out_c_next,
  output logic [LANES*DATA_W-1:0] out_h,
  output logic                    frame_err
);

  localparam int BEATS = HIDDEN / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BEATS - 1);

  if (HIDDEN % LANES != 0) begin : g_bad_lanes
    $error("HIDDEN must be a multiple of LANES");
  end
  if (DATA_W != FX_W || FRAC_W != FX_FRAC) begin : g_bad_fmt
    $error("DATA_W/FRAC_W must match lstm_fx_pkg");
  end

  logic [3:0]    v_q;
  logic [3:0]    l_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_q;
  logic          stall;
  logic          acc;
  logic          is_max;
  logic          tag;

  assign stall    = v_q[3] && !out_ready;
  assign in_ready = !stall;
  assign acc      = in_valid && in_ready;

  // Beat position and last tag; an early in_last resyncs to 0
  always_comb begin
    is_max = (cnt_q == CNT_MAX);
    tag    = is_max || in_last;
    cnt_d  = tag ? '0 : cnt_q + 1'b1;
  end

  // Valid/last shift chain, beat counter, sticky framing error
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      l_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!stall) begin
        v_q <= {v_q[2:0], in_valid};
        l_q <= {l_q[2:0], in_valid && tag};
      end
      if (acc) begin
        cnt_q <= cnt_d;
        if (in_last != is_max) err_q <= 1'b1;
      end
    end
  end

  assign out_valid = v_q[3];
  assign out_last  = l_q[3];
  assign frame_err = err_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lstm_lane_datapath #(
      .CLIP (fx_t'(CELL_CLIP))
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en_i (!stall),
      .f_i  (in_f[l*DATA_W +: DATA_W]),
      .g_i  (in_g[l*DATA_W +: DATA_W]),
      .i_i  (in_i[l*DATA_W +: DATA_W]),
      .o_i  (in_o[l*DATA_W +: DATA_W]),
      .cp_i (in_c_prev[l*DATA_W +: DATA_W]),
      .c_o  (out_c_next[l*DATA_W +: DATA_W]),
      .h_o  (out_h[l*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/lstm_cell_update_pipe.md
Name: lstm_cell_update_pipe

Overview:
Streaming, parametrised LSTM cell-state/hidden update. Takes pre-activation gate vectors f, g, i, o and c_prev, LANES elements per beat. Computes c_next = σ(f)·c_prev + σ(i)·tanh(g) and h_t = σ(o)·tanh(c_next) in a 4-stage pipeline with valid/ready handshake.
Sits between the gate matrix-multiply engine (upstream) and the h/c state buffers (downstream). Replaces the fixed-size, purely combinational 100-element gate combiner.

Parameters:
HIDDEN, 100, hidden vector length (elements per frame)
LANES, 4, elements processed per beat; HIDDEN % LANES must be 0 (elaboration error otherwise)
DATA_W, 32, signed fixed-point word width
FRAC_W, 16, fractional bits (default Q16.16, ONE = 1<<FRAC_W)
CELL_CLIP, 4<<FRAC_W, |c_next| bound; used only with LSTM_CELL_CLIP_EN

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_last  in  1  upstream marks final beat of frame
in_f  in  LANES*DATA_W  forget-gate pre-activations, lane 0 in LSBs
in_g  in  LANES*DATA_W  candidate pre-activations
in_i  in  LANES*DATA_W  input-gate pre-activations
in_o  in  LANES*DATA_W  output-gate pre-activations
in_c_prev  in  LANES*DATA_W  previous cell state
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_last  out  1  final beat of frame
out_c_next  out  LANES*DATA_W  new cell state
out_h  out  LANES*DATA_W  new hidden state
frame_err  out  1  sticky in_last/beat-count mismatch

Behaviour:
- Clock/reset: one clock clk; rst is synchronous, active-high.
- Reset values: out_valid=0, out_last=0, out_c_next=0, out_h=0, frame_err=0. All stage valids=0; beat counters=0. in_ready=1 one cycle after reset releases.
- Reset mid-frame: all in-flight beats are discarded and the counters restart at 0.
- Accept: a beat transfers when in_valid && in_ready.
- Output transfer: a beat transfers when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall.
  - On stall, all stages hold.
  - No bubbles are squeezed; the stall is global.
  - Outputs stay stable while stalled.
- Latency: 4 cycles from accept to out_valid, with no stalls. Throughput: 1 beat/cycle.
- Pipeline:
  - S1: hsig(f), hsig(i), hsig(o), htanh(g); register c_prev.
  - S2: p_f = hsig(f)·c_prev, p_i = hsig(i)·htanh(g).
  - S3: c = sat(p_f + p_i).
  - S4: h = hsig(o)·htanh(c). c is registered alongside h.
- Activations (exact, piecewise linear):
  - hsig(x) = clamp((x>>>2) + ONE/2, 0, ONE).
  - htanh(x) = clamp(x, -ONE, +ONE).
- Multiply: full 2·DATA_W product. Add 1<<(FRAC_W-1), arithmetic shift right by FRAC_W, then saturate to DATA_W.
- Add: DATA_W+1 bit sum, saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Frame tracking:
  - in_cnt counts accepted beats over 0..HIDDEN/LANES-1 and wraps.
  - Each beat carries a last tag = (in_cnt == max). The tag travels with the data and drives out_last.
  - in_last=1 with in_cnt != max: set frame_err, force in_cnt to 0 for the next beat (resync), and tag this beat last.
  - in_last=0 with in_cnt == max: set frame_err; the counter wraps normally.
  - frame_err clears only on rst.
- Simultaneous accept and output on the same cycle is legal. The pipeline advances.

Optional Feature:
LSTM_CELL_CLIP_EN.
- Defined: S3 result is additionally clamped to [-CELL_CLIP, +CELL_CLIP] before registration. Latency is unchanged.
- Undefined: only DATA_W saturation applies, and CELL_CLIP is unused.

Decomposition:
- Package lstm_fx_pkg holds:
  - ONE/HALF constants derived from FRAC_W;
  - the sat_add, fx_mul_rnd, hsig and htanh functions;
  - the lane-slice typedef fx_t = logic signed [DATA_W-1:0].
- Sub-module lstm_lane_datapath covers one lane's S1–S4 arithmetic, with an enable input and no control.
- Top instantiates LANES of them in a generate loop, plus shared valid/last/stall/counter control.

Test Plan:
1. LANES=4, all lanes: f=0, c_prev=0x00020000, i=0x00080000, g=0x00008000, o=0xFFF80000.
   -> c_next=0x00018000, h=0, out_valid exactly 4 cycles after accept.
2. Same as 1 but o=0x00020000.
   -> h=0x00010000 (htanh(1.5) clamps to 1.0).
3. c_prev=0x7FFF0000, f=0x00080000, i=0x00080000, g=0x00010000.
   -> c_next=0x7FFFFFFF (saturate); negated inputs -> 0x80000000.
4. 25 back-to-back beats with out_ready toggling 1,0,0,0,1 pattern.
   -> all 25 outputs in order, none lost or duplicated, outputs stable while stalled, out_last only on beat 25.
5. in_last on beat 10.
   -> frame_err=1, out_last on beat 10, next beat starts new frame; rst mid-stream -> out_valid=0 next cycle, frame_err=0.
6. With LSTM_CELL_CLIP_EN: stimulus from case 3.
   -> c_next=0x00040000, h=0x00010000; without the macro, this case reverts to the case 3 result.
